// File: rtl/mem_req_ctrl_if.sv
// ============================================================================
// mem_req_ctrl_if : pipeline request/response and mem_system bus bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface mem_req_ctrl_if;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_hit;
    logic        resp_err;
    logic [15:0] mem_Addr;
    logic [15:0] mem_DataIn;
    logic        mem_Rd;
    logic        mem_Wr;
    logic [15:0] mem_DataOut;
    logic        mem_Done;
    logic        mem_Stall;
    logic        mem_CacheHit;
    logic        mem_err;

    // Pipeline stage and memory model together form the master side
    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        output mem_DataOut, mem_Done, mem_Stall, mem_CacheHit, mem_err,
        input  req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
        input  mem_Addr, mem_DataIn, mem_Rd, mem_Wr
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        input  mem_DataOut, mem_Done, mem_Stall, mem_CacheHit, mem_err,
        output req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
        output mem_Addr, mem_DataIn, mem_Rd, mem_Wr
    );
endinterface

`default_nettype wire

// File: rtl/mem_req_ctrl.sv
// ============================================================================
// mem_req_ctrl : single-outstanding load/store sequencer in front of mem_system
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_req_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    mem_req_ctrl_if.slave         bus,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      acc_cnt
);

    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [15:0]     lat_addr;
    logic [15:0]     lat_wdata;
    logic            lat_wr;
    logic            err_sticky;
    logic [WD_W-1:0] wdog;
    logic [15:0]     rsp_rdata;
    logic            rsp_hit;
    logic            rsp_err;

    logic            ready;
    logic            rd_pulse;
    logic            wr_pulse;
    logic            rsp_strobe;
    logic            wdog_expired;

    assign wdog_expired = (wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        rd_pulse   = 1'b0;
        wr_pulse   = 1'b0;
        rsp_strobe = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    next_state = bus.req_addr[0] ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.mem_Stall) begin
                    rd_pulse   = !lat_wr;
                    wr_pulse   = lat_wr;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_Done || wdog_expired) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_strobe = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wr     <= 1'b0;
            err_sticky <= 1'b0;
            wdog       <= '0;
            rsp_rdata  <= '0;
            rsp_hit    <= 1'b0;
            rsp_err    <= 1'b0;
            hit_cnt    <= '0;
            acc_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_addr   <= bus.req_addr;
                        lat_wdata  <= bus.req_wdata;
                        lat_wr     <= bus.req_wr;
                        err_sticky <= 1'b0;
                        if (bus.req_addr[0]) begin
                            rsp_rdata <= '0;
                            rsp_hit   <= 1'b0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wdog <= '0;
                end
                WAIT: begin
                    wdog <= wdog + WD_W'(1);
                    if (bus.mem_err) begin
                        err_sticky <= 1'b1;
                    end
                    // Done wins over the watchdog when both land in the same cycle
                    if (bus.mem_Done) begin
                        rsp_hit <= bus.mem_CacheHit;
                        rsp_err <= bus.mem_err | err_sticky;
                        rsp_rdata <= (lat_wr || bus.mem_err || err_sticky) ? 16'h0000
                                                                             : bus.mem_DataOut;
                    end else if (wdog_expired) begin
                        rsp_rdata <= '0;
                        rsp_hit   <= 1'b0;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (!rsp_err && (acc_cnt != {CNT_W{1'b1}})) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                    if (rsp_hit && (hit_cnt != {CNT_W{1'b1}})) begin
                        hit_cnt <= hit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = rsp_strobe;
    assign bus.resp_rdata = rsp_rdata;
    assign bus.resp_hit   = rsp_hit;
    assign bus.resp_err   = rsp_err;
    assign bus.mem_Addr   = lat_addr;
    assign bus.mem_DataIn = lat_wdata;
    assign bus.mem_Rd     = rd_pulse;
    assign bus.mem_Wr     = wr_pulse;

endmodule

`default_nettype wire

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request sequencer between the pipeline memory stage and the cache/memory system (mem_system).
- Accepts one load/store per handshake and latches it. Holds Addr/DataIn stable for the whole access and pulses Rd/Wr for exactly one cycle.
- Waits for Done, captures read data and hit status, then returns a one-cycle response.
- Also provides misalignment checking, a watchdog timeout and saturating hit/access counters.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before an error response (must be ≥ 2).
- CNT_W, 16, width of the hit/access statistics counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline request present
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  16  byte address
- req_wdata  in  16  store data
- req_ready  out  1  controller can accept a request this cycle
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  16  load data (0 for stores and errors)
- resp_hit  out  1  access hit in cache
- resp_err  out  1  misaligned, mem_err or timeout
- mem_Addr  out  16  to mem_system Addr
- mem_DataIn  out  16  to mem_system DataIn
- mem_Rd  out  1  to mem_system Rd
- mem_Wr  out  1  to mem_system Wr
- mem_DataOut  in  16  from mem_system
- mem_Done  in  1  from mem_system
- mem_Stall  in  1  from mem_system
- mem_CacheHit  in  1  from mem_system
- mem_err  in  1  from mem_system
- hit_cnt  out  CNT_W  saturating count of hits
- acc_cnt  out  CNT_W  saturating count of completed accesses

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE.
  - All outputs 0 except req_ready = 1.
  - Latched address, data and op are cleared; counters are cleared.
  - Reset asserted mid-access aborts the access with no response. mem_Rd/mem_Wr drop immediately.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_addr, req_wdata, req_wr.
  - If req_addr[0] = 1: go to RESP with err set and no memory access.
  - Otherwise go to ISSUE.
- ISSUE:
  - req_ready = 0.
  - mem_Addr and mem_DataIn are driven from the latches. They stay stable from ISSUE through WAIT.
  - If mem_Stall = 0: assert mem_Rd (load) or mem_Wr (store) for this single cycle, then go to WAIT.
  - If mem_Stall = 1: hold in ISSUE with Rd/Wr low.
  - mem_Rd and mem_Wr are never high together, and never high outside ISSUE.
- WAIT:
  - Watchdog counter starts at 0 and increments each cycle.
  - On mem_Done: capture mem_DataOut (loads only; stores capture 0) and mem_CacheHit into resp_hit. err = mem_err. Go to RESP.
  - mem_err alone, without Done, sets sticky err; the controller keeps waiting.
  - If the counter reaches TIMEOUT−1 without Done: err = 1, resp_hit = 0, rdata = 0, go to RESP.
  - mem_Done in any other state is ignored.
- RESP:
  - resp_valid = 1 for one cycle; resp_rdata, resp_hit and resp_err are valid that cycle and hold until the next response.
  - acc_cnt increments if err = 0; hit_cnt increments if resp_hit = 1. Both saturate at all-ones.
  - Go to IDLE; req_ready returns high the next cycle.
- Latency:
  - Accept at cycle T (IDLE with req_valid); mem_Rd/mem_Wr at T+1.
  - A cache hit returns mem_Done at T+2, giving resp_valid at T+3.
  - A miss returns resp_valid one cycle after mem_Done.
  - A misaligned request gives resp_valid at T+1.
- Throughput: at most one outstanding request; back-to-back accepts are spaced by at least one RESP cycle.
- req_valid while req_ready = 0 is ignored; the upstream stage must hold its request until it sees ready.

Test Plan:
- Load hit: preload address 0x0010 with 0xBEEF. Request load 0x0010 at T → mem_Rd is high only at T+1, resp_valid at T+3, rdata 0xBEEF, hit 1, err 0, acc_cnt +1, hit_cnt +1.
- Store miss, then load: store 0xA5A5 to 0x1238 → single mem_Wr pulse, mem_Addr holds 0x1238 until Done, resp hit 0. A following load of 0x1238 returns 0xA5A5 with hit 1.
- Misaligned: load 0x0003 → resp_valid at T+1, err 1, mem_Rd/mem_Wr never asserted, acc_cnt unchanged.
- Stall in ISSUE: hold mem_Stall = 1 for 3 cycles → controller stays in ISSUE with Rd low, issues in the first cycle mem_Stall = 0, and the response is correct.
- Timeout: stub memory never asserts Done, TIMEOUT = 8 → resp_valid 8 cycles after entering WAIT, err 1, rdata 0. A spurious Done after that cycle is ignored.
- Reset mid-miss: pull rst_n low during WAIT → outputs return to reset values immediately, no resp_valid, counters 0, req_ready 1 after release.
